// File: rtl/multi_dac_generator_pkg.sv
// multi_dac_generator_pkg: shared DAC frame constants, mode codes and sequencer states
package multi_dac_generator_pkg;
  localparam logic [3:0] DAC_CMD_WRITE_UPDATE = 4'b0011;
  localparam int FRAME_BITS = 32;
  typedef enum logic [1:0] {MODE_SAW, MODE_TRI, MODE_SQR, MODE_DC} mode_e;
  typedef enum logic [2:0] {IDLE, LOAD, CS_LOW, SHIFT, CS_HIGH} state_e;
  function automatic logic [FRAME_BITS-1:0] dac_frame(input logic [3:0] addr, input logic [11:0] data);
    return {8'h00, DAC_CMD_WRITE_UPDATE, addr, data, 4'h0};
  endfunction
endpackage

// File: rtl/multi_dac_generator_if.sv
// multi_dac_generator_if: SPI DAC pin bundle
interface multi_dac_generator_if;
  logic spi_mosi;
  logic spi_sck;
  logic dac_cs;
  logic dac_clr;
  modport master(output spi_mosi, spi_sck, dac_cs, dac_clr);
  modport slave(input spi_mosi, spi_sck, dac_cs, dac_clr);
endinterface

// File: rtl/multi_dac_generator_spi_dac_tx.sv
// spi_dac_tx: shifts one 32-bit DAC frame MSB first, sck idle low, done on the last falling edge
module spi_dac_tx
  import multi_dac_generator_pkg::*;
#(
  parameter int SIZE     = 12,
  parameter int SCK_HALF = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      addr,
  input  logic [SIZE-1:0] data,
  output logic            spi_mosi,
  output logic            spi_sck,
  output logic            dac_cs,
  output logic            done
);
  localparam int HW = SCK_HALF > 1 ? $clog2(SCK_HALF) : 1;
  logic [FRAME_BITS-1:0] sr;
  logic [HW-1:0] hcnt;
  logic [4:0] bcnt;
  logic half;
  assign half = !dac_cs && hcnt == HW'(SCK_HALF - 1);
  assign done = half && spi_sck && bcnt == 5'd31;
  // sr drains to zero after 32 shifts, so mosi idles low without extra logic
  assign spi_mosi = sr[FRAME_BITS-1];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr      <= '0;
      hcnt    <= '0;
      bcnt    <= '0;
      spi_sck <= 1'b0;
      dac_cs  <= 1'b1;
    end else if (dac_cs) begin
      if (start) begin
        sr     <= dac_frame(addr, 12'(data) << (12 - SIZE));
        dac_cs <= 1'b0;
        hcnt   <= '0;
        bcnt   <= '0;
      end
    end else if (half) begin
      hcnt    <= '0;
      spi_sck <= !spi_sck;
      if (spi_sck) begin
        sr     <= sr << 1;
        bcnt   <= bcnt + 5'd1;
        dac_cs <= bcnt == 5'd31;
      end
    end else
      hcnt <= hcnt + 1'b1;
endmodule

// File: rtl/multi_dac_generator.sv
// multi_dac_generator: multi-channel DDS waveform generator streaming samples to a 4-channel SPI DAC
module multi_dac_generator
  import multi_dac_generator_pkg::*;
#(
  parameter int DIV      = 50000,
  parameter int SIZE     = 12,
  parameter int PHASE_W  = 16,
  parameter int CHANNELS = 2,
  parameter int SCK_HALF = 2,
  parameter int CS_GAP   = 2,
  parameter int CLR_CYC  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [CHANNELS*PHASE_W-1:0]   ch_ftw,
  input  logic [CHANNELS*2-1:0]         ch_mode,
  input  logic                          overrun_clr,
  multi_dac_generator_if.master         dac,
  output logic                          busy,
  output logic                          overrun
);
  localparam int CW  = $clog2(DIV);
  localparam int CLW = $clog2(CLR_CYC + 1);
  localparam int GW  = $clog2(CS_GAP + 1);
  localparam int AW  = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  state_e state;
  logic [CW-1:0] cnt;
  logic [CLW-1:0] clr_cnt;
  logic [GW-1:0] gcnt;
  logic [AW-1:0] ch;
  logic tick, accept, done;
  logic [PHASE_W-1:0] acc [CHANNELS];
  logic [SIZE-1:0] p [CHANNELS];
  logic [SIZE-1:0] smp [CHANNELS];
  logic [SIZE-1:0] buf_q [CHANNELS];
  mode_e md [CHANNELS];
  assign tick   = en && cnt == CW'(DIV - 1);
  assign accept = tick && dac.dac_clr && state == IDLE;
  always_comb
    for (int i = 0; i < CHANNELS; i++) begin
      md[i]  = mode_e'(ch_mode[i*2 +: 2]);
      p[i]   = acc[i][PHASE_W-1 -: SIZE];
      smp[i] = md[i] == MODE_DC  ? ch_ftw[i*PHASE_W +: SIZE] :
               md[i] == MODE_SQR ? {SIZE{p[i][SIZE-1]}} :
               md[i] == MODE_TRI ? {p[i][SIZE-2:0], 1'b0} ^ {SIZE{p[i][SIZE-1]}} : p[i];
    end
  // samples are taken from the pre-increment phase; DC channels keep their phase frozen
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i]   <= '0;
        buf_q[i] <= '0;
      end
    else if (accept)
      for (int i = 0; i < CHANNELS; i++) begin
        buf_q[i] <= smp[i];
        if (md[i] != MODE_DC) acc[i] <= acc[i] + ch_ftw[i*PHASE_W +: PHASE_W];
      end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      clr_cnt     <= '0;
      gcnt        <= '0;
      ch          <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      dac.dac_clr <= 1'b0;
    end else begin
      if (en) cnt <= tick ? '0 : cnt + 1'b1;
      if (!dac.dac_clr) begin
        clr_cnt     <= clr_cnt + 1'b1;
        dac.dac_clr <= clr_cnt == CLW'(CLR_CYC - 1);
      end
      overrun <= (tick && state != IDLE) || (overrun && !overrun_clr);
      case (state)
        IDLE: if (accept) begin
          state <= LOAD;
          busy  <= 1'b1;
        end
        LOAD: begin
          ch    <= '0;
          state <= CS_LOW;
        end
        CS_LOW: state <= SHIFT;
        SHIFT: if (done) begin
          gcnt  <= '0;
          state <= int'(ch) == CHANNELS - 1 ? IDLE : CS_HIGH;
          busy  <= int'(ch) != CHANNELS - 1;
        end
        // cs rose with the leaving SHIFT edge and CS_LOW costs one more clk before it falls
        CS_HIGH: if (int'(gcnt) >= CS_GAP - 2) begin
          ch    <= ch + 1'b1;
          state <= CS_LOW;
        end else
          gcnt <= gcnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  spi_dac_tx #(.SIZE(SIZE), .SCK_HALF(SCK_HALF)) u_tx (
    .clk(clk),
    .rst(rst),
    .start(state == CS_LOW),
    .addr(4'(ch)),
    .data(buf_q[ch]),
    .spi_mosi(dac.spi_mosi),
    .spi_sck(dac.spi_sck),
    .dac_cs(dac.dac_cs),
    .done(done)
  );
endmodule

// File: tb/tb_multi_dac_generator.sv
// tb_multi_dac_generator: directed checks of frames, waveforms, sequencing, overrun and reset
module tb_multi_dac_generator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, en2 = 1'b0, clr2 = 1'b0;
  logic busy, busy2, ovr, ovr2;
  logic [31:0] ftw = '0;
  logic [3:0] mode = '0;
  int n_chk = 0, n_fail = 0;
  logic [31:0] q_f[$];
  int q_b[$];
  logic [31:0] sh = '0;
  int bits = 0, gcnt = 0, last_gap = 0, nfall = 0;
  logic pcs = 1'b1;
  multi_dac_generator_if dac();
  multi_dac_generator_if dac2();
  always #5 clk = ~clk;
  multi_dac_generator #(.DIV(400), .CHANNELS(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .ch_ftw(ftw), .ch_mode(mode), .overrun_clr(1'b0),
    .dac(dac), .busy(busy), .overrun(ovr)
  );
  multi_dac_generator #(.DIV(20), .CHANNELS(2)) u_ov (
    .clk(clk), .rst(rst), .en(en2), .ch_ftw(ftw), .ch_mode(mode), .overrun_clr(clr2),
    .dac(dac2), .busy(busy2), .overrun(ovr2)
  );
  always @(negedge dac.dac_cs) begin
    sh = '0;
    bits = 0;
  end
  always @(posedge dac.spi_sck) begin
    sh = {sh[30:0], dac.spi_mosi};
    bits++;
  end
  always @(posedge dac.dac_cs) begin
    q_f.push_back(sh);
    q_b.push_back(bits);
  end
  always @(negedge clk) begin
    if (dac.dac_cs && !pcs) gcnt = 1;
    else if (dac.dac_cs) gcnt++;
    else if (pcs) begin
      last_gap = gcnt;
      nfall++;
    end
    pcs = dac.dac_cs;
  end
  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic exp_frame(input string tag, input logic [31:0] exp);
    int t = 0;
    while (q_f.size() == 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    chk({tag, "_present"}, 32'(q_f.size() != 0), 32'd1);
    if (q_f.size() != 0) begin
      chk(tag, q_f.pop_front(), exp);
      chk({tag, "_sck"}, 32'(q_b.pop_front()), 32'd32);
    end
  endtask
  task automatic do_reset();
    en = 1'b0;
    rst = 1'b1;
    clk_n(2);
    rst = 1'b0;
    clk_n(20);
    q_f.delete();
    q_b.delete();
  endtask
  task automatic wait_cs_low();
    int t = 0;
    while (dac.dac_cs && t < 1000) begin
      @(posedge clk);
      t++;
    end
    chk("cs_fall_seen", 32'(dac.dac_cs), 32'd0);
    clk_n(1);
  endtask
  initial begin
    int t;
    int nf;
    clk_n(3);
    chk("rst_cs", 32'(dac.dac_cs), 32'd1);
    chk("rst_sck", 32'(dac.spi_sck), 32'd0);
    chk("rst_mosi", 32'(dac.spi_mosi), 32'd0);
    chk("rst_clr", 32'(dac.dac_clr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(ovr), 32'd0);
    rst = 1'b0;
    clk_n(15);
    chk("clr_low_15", 32'(dac.dac_clr), 32'd0);
    clk_n(1);
    chk("clr_high_16", 32'(dac.dac_clr), 32'd1);
    // overrun on the fast-tick instance: ticks every 20 clks, accepted tick at +20, dropped at +40
    en2 = 1'b1;
    clk_n(30);
    chk("ov_busy", 32'(busy2), 32'd1);
    chk("ov_before", 32'(ovr2), 32'd0);
    clk_n(20);
    chk("ov_set", 32'(ovr2), 32'd1);
    en2 = 1'b0;
    clr2 = 1'b1;
    clk_n(1);
    clr2 = 1'b0;
    chk("ov_cleared", 32'(ovr2), 32'd0);
    clk_n(1);
    en2 = 1'b1;
    clk_n(8);
    clr2 = 1'b1;
    clk_n(2);
    clr2 = 1'b0;
    chk("ov_set_wins", 32'(ovr2), 32'd1);
    clk_n(1);
    chk("ov_sticky", 32'(ovr2), 32'd1);
    en2 = 1'b0;
    // saw ch0 + DC ch1
    q_f.delete();
    q_b.delete();
    ftw = {16'h0ABC, 16'h1000};
    mode = {2'd3, 2'd0};
    en = 1'b1;
    exp_frame("saw_t1_ch0", 32'h0030_0000);
    exp_frame("dc_t1_ch1", 32'h0031_ABC0);
    chk("cs_gap", 32'(last_gap), 32'd2);
    exp_frame("saw_t2_ch0", 32'h0030_1000);
    exp_frame("dc_t2_ch1", 32'h0031_ABC0);
    exp_frame("saw_t3_ch0", 32'h0030_2000);
    exp_frame("dc_t3_ch1", 32'h0031_ABC0);
    chk("no_overrun", 32'(ovr), 32'd0);
    // phase wrap
    do_reset();
    ftw = {16'h0ABC, 16'hC000};
    en = 1'b1;
    exp_frame("wrap_t1", 32'h0030_0000);
    exp_frame("wrap_t1_ch1", 32'h0031_ABC0);
    exp_frame("wrap_t2", 32'h0030_C000);
    exp_frame("wrap_t2_ch1", 32'h0031_ABC0);
    exp_frame("wrap_t3", 32'h0030_8000);
    exp_frame("wrap_t3_ch1", 32'h0031_ABC0);
    exp_frame("wrap_t4", 32'h0030_4000);
    exp_frame("wrap_t4_ch1", 32'h0031_ABC0);
    // triangle ch0, square ch1
    do_reset();
    ftw = {16'h4000, 16'h4000};
    mode = {2'd2, 2'd1};
    en = 1'b1;
    exp_frame("tri_t1", 32'h0030_0000);
    exp_frame("sqr_t1", 32'h0031_0000);
    exp_frame("tri_t2", 32'h0030_8000);
    exp_frame("sqr_t2", 32'h0031_0000);
    exp_frame("tri_t3", 32'h0030_FFF0);
    exp_frame("sqr_t3", 32'h0031_FFF0);
    exp_frame("tri_t4", 32'h0030_7FF0);
    exp_frame("sqr_t4", 32'h0031_FFF0);
    // en dropped mid-frame: the sequence completes, then nothing more
    do_reset();
    mode = {2'd3, 2'd0};
    ftw = {16'h0ABC, 16'h1000};
    en = 1'b1;
    wait_cs_low();
    clk_n(20);
    en = 1'b0;
    t = 0;
    while (busy && t < 1000) begin
      clk_n(1);
      t++;
    end
    chk("en_off_busy", 32'(busy), 32'd0);
    exp_frame("en_off_ch0", 32'h0030_0000);
    exp_frame("en_off_ch1", 32'h0031_ABC0);
    nf = nfall;
    clk_n(1000);
    chk("en_off_no_cs", 32'(nfall), 32'(nf));
    // async reset mid-frame
    en = 1'b1;
    wait_cs_low();
    clk_n(10);
    rst = 1'b1;
    #1;
    chk("abort_cs", 32'(dac.dac_cs), 32'd1);
    chk("abort_sck", 32'(dac.spi_sck), 32'd0);
    chk("abort_mosi", 32'(dac.spi_mosi), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_clr", 32'(dac.dac_clr), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog");
  end
endmodule
